// File: rtl/wb_commit_unit_if.sv
// MEM/WB write-back bundle, ID read ports and the debug commit trace.
interface wb_commit_unit_if;
    logic [31:0] PC_plus_4_latch_in;
    logic [31:0] CP0_data_in;
    logic [31:0] ALU_result_in;
    logic [31:0] Memory_or_IO_read_data_in;
    logic        Jal_in;
    logic        Jalr_in;
    logic        Bgezal_in;
    logic        Bltzal_in;
    logic        Mfc0_in;
    logic        Memory_or_IO_in;
    logic        Zero_in;
    logic        Positive_in;
    logic        Negative_in;
    logic        Register_write_in;
    logic [4:0]  Write_back_address_in;
    logic [4:0]  Read_address_1;
    logic [4:0]  Read_address_2;
    logic [31:0] Read_data_1;
    logic [31:0] Read_data_2;
    logic        Commit_valid;
    logic [4:0]  Commit_address;
    logic [31:0] Commit_data;
    logic [31:0] Retired_count;

    // Pipeline side driving the write-back stage.
    modport master (
        output PC_plus_4_latch_in, CP0_data_in, ALU_result_in, Memory_or_IO_read_data_in,
        output Jal_in, Jalr_in, Bgezal_in, Bltzal_in, Mfc0_in, Memory_or_IO_in,
        output Zero_in, Positive_in, Negative_in, Register_write_in, Write_back_address_in,
        output Read_address_1, Read_address_2,
        input  Read_data_1, Read_data_2, Commit_valid, Commit_address, Commit_data,
        input  Retired_count
    );

    // Write-back stage itself.
    modport slave (
        input  PC_plus_4_latch_in, CP0_data_in, ALU_result_in, Memory_or_IO_read_data_in,
        input  Jal_in, Jalr_in, Bgezal_in, Bltzal_in, Mfc0_in, Memory_or_IO_in,
        input  Zero_in, Positive_in, Negative_in, Register_write_in, Write_back_address_in,
        input  Read_address_1, Read_address_2,
        output Read_data_1, Read_data_2, Commit_valid, Commit_address, Commit_data,
        output Retired_count
    );
endinterface

// File: rtl/wb_commit_unit.sv
// Minisys-1A write-back stage: selects the write-back value/destination, owns the
// 32x32 register file with write-to-read bypass, and keeps a commit trace and counter.
module wb_commit_unit (
    input logic             clock,
    input logic             reset,
    wb_commit_unit_if.slave bus
);
    logic [31:0] regs_q [32];
    logic        commit_valid_q;
    logic [4:0]  commit_address_q;
    logic [31:0] commit_data_q;
    logic [31:0] retired_q;

    logic        link_any;
    logic [31:0] wdata;
    logic [4:0]  dest;
    logic        we;

    // Select write data, destination and write enable from the MEM/WB bundle.
    always_comb begin
        link_any = bus.Jal_in | bus.Jalr_in | bus.Bgezal_in | bus.Bltzal_in;

        if (link_any) begin
            wdata = bus.PC_plus_4_latch_in;
        end else if (bus.Mfc0_in) begin
            wdata = bus.CP0_data_in;
        end else if (bus.Memory_or_IO_in) begin
            wdata = bus.Memory_or_IO_read_data_in;
        end else begin
            wdata = bus.ALU_result_in;
        end

        // Jalr links to its rd field; the other link forms hard-wire $ra.
        if (bus.Jal_in | bus.Bgezal_in | bus.Bltzal_in) begin
            dest = 5'd31;
        end else begin
            dest = bus.Write_back_address_in;
        end

        if (bus.Jal_in | bus.Jalr_in) begin
            we = 1'b1;
        end else if (bus.Bgezal_in) begin
            we = bus.Zero_in | bus.Positive_in;
        end else if (bus.Bltzal_in) begin
            we = bus.Negative_in;
        end else begin
            we = bus.Register_write_in;
        end

        if (dest == 5'd0) begin
            we = 1'b0;
        end
    end

    // Read ports: r0 is zero, an in-flight write to the same register is bypassed.
    always_comb begin
        if (bus.Read_address_1 == 5'd0) begin
            bus.Read_data_1 = 32'd0;
        end else if (we && (dest == bus.Read_address_1)) begin
            bus.Read_data_1 = wdata;
        end else begin
            bus.Read_data_1 = regs_q[bus.Read_address_1];
        end

        if (bus.Read_address_2 == 5'd0) begin
            bus.Read_data_2 = 32'd0;
        end else if (we && (dest == bus.Read_address_2)) begin
            bus.Read_data_2 = wdata;
        end else begin
            bus.Read_data_2 = regs_q[bus.Read_address_2];
        end
    end

    // Register file commit; reset clears every entry immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (we) begin
            regs_q[dest] <= wdata;
        end
    end

    // Commit trace and retired-write counter for the debug path.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            commit_valid_q   <= 1'b0;
            commit_address_q <= 5'd0;
            commit_data_q    <= 32'd0;
            retired_q        <= 32'd0;
        end else begin
            commit_valid_q <= we;
            if (we) begin
                commit_address_q <= dest;
                commit_data_q    <= wdata;
                retired_q        <= retired_q + 32'd1;
            end
        end
    end

    assign bus.Commit_valid   = commit_valid_q;
    assign bus.Commit_address = commit_address_q;
    assign bus.Commit_data    = commit_data_q;
    assign bus.Retired_count  = retired_q;
endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed, table-driven bench for wb_commit_unit plus reset and counter-wrap sequences.
module tb_wb_commit_unit;
    logic clock;
    logic reset;

    wb_commit_unit_if bus ();

    wb_commit_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Flag bit positions: {jal, jalr, bgezal, bltzal, mfc0, mem, zero, pos, neg, rw}
    localparam logic [9:0] JAL    = 10'b10_0000_0000;
    localparam logic [9:0] JALR   = 10'b01_0000_0000;
    localparam logic [9:0] BGEZAL = 10'b00_1000_0000;
    localparam logic [9:0] BLTZAL = 10'b00_0100_0000;
    localparam logic [9:0] MFC0   = 10'b00_0010_0000;
    localparam logic [9:0] MEM    = 10'b00_0001_0000;
    localparam logic [9:0] ZERO   = 10'b00_0000_1000;
    localparam logic [9:0] POS    = 10'b00_0000_0100;
    localparam logic [9:0] NEG    = 10'b00_0000_0010;
    localparam logic [9:0] RW     = 10'b00_0000_0001;
    localparam logic [9:0] NONE   = 10'b00_0000_0000;

    typedef struct {
        logic [9:0]  flags;
        logic [4:0]  wa;
        logic [31:0] pc4;
        logic [31:0] cp0;
        logic [31:0] alu;
        logic [31:0] memd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] rd1;  // expected before the edge
        logic [31:0] rd2;
        logic        cv;   // expected after the edge
        logic [4:0]  ca;
        logic [31:0] cd;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs [15];

    int compared;
    int mismatched;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic [9:0] flags, input logic [4:0] wa, input logic [31:0] pc4,
                         input logic [31:0] cp0, input logic [31:0] alu, input logic [31:0] memd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        {bus.Jal_in, bus.Jalr_in, bus.Bgezal_in, bus.Bltzal_in, bus.Mfc0_in,
         bus.Memory_or_IO_in, bus.Zero_in, bus.Positive_in, bus.Negative_in,
         bus.Register_write_in} = flags;
        bus.Write_back_address_in     = wa;
        bus.PC_plus_4_latch_in        = pc4;
        bus.CP0_data_in               = cp0;
        bus.ALU_result_in             = alu;
        bus.Memory_or_IO_read_data_in = memd;
        bus.Read_address_1            = ra1;
        bus.Read_address_2            = ra2;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        vecs[0]  = '{RW,                   5'd5,  32'h0,   32'h0, 32'h1234, 32'h0,
                     5'd5,  5'd0,  32'h1234, 32'h0,    1'b1, 5'd5,  32'h1234, 32'd1};
        vecs[1]  = '{RW | MEM,             5'd7,  32'h0,   32'h0, 32'hA,    32'hB,
                     5'd7,  5'd5,  32'hB,    32'h1234, 1'b1, 5'd7,  32'hB,    32'd2};
        vecs[2]  = '{RW | MEM | MFC0,      5'd7,  32'h0,   32'hC, 32'hA,    32'hB,
                     5'd7,  5'd5,  32'hC,    32'h1234, 1'b1, 5'd7,  32'hC,    32'd3};
        vecs[3]  = '{RW | MEM | MFC0 | JALR, 5'd7, 32'h40, 32'hC, 32'hA,    32'hB,
                     5'd7,  5'd5,  32'h40,   32'h1234, 1'b1, 5'd7,  32'h40,   32'd4};
        vecs[4]  = '{BGEZAL | NEG,         5'd3,  32'h200, 32'h0, 32'h0,    32'h0,
                     5'd31, 5'd7,  32'h0,    32'h40,   1'b0, 5'd7,  32'h40,   32'd4};
        vecs[5]  = '{BLTZAL | NEG,         5'd3,  32'h100, 32'h0, 32'h0,    32'h0,
                     5'd31, 5'd7,  32'h100,  32'h40,   1'b1, 5'd31, 32'h100,  32'd5};
        vecs[6]  = '{RW,                   5'd0,  32'h0,   32'h0, 32'hFFFF, 32'h0,
                     5'd0,  5'd31, 32'h0,    32'h100,  1'b0, 5'd31, 32'h100,  32'd5};
        vecs[7]  = '{RW,                   5'd9,  32'h0,   32'h0, 32'h55,   32'h0,
                     5'd8,  5'd9,  32'h0,    32'h55,   1'b1, 5'd9,  32'h55,   32'd6};
        vecs[8]  = '{JAL,                  5'd4,  32'h300, 32'h0, 32'h0,    32'h0,
                     5'd31, 5'd4,  32'h300,  32'h0,    1'b1, 5'd31, 32'h300,  32'd7};
        vecs[9]  = '{BGEZAL | ZERO,        5'd4,  32'h400, 32'h0, 32'h0,    32'h0,
                     5'd31, 5'd9,  32'h400,  32'h55,   1'b1, 5'd31, 32'h400,  32'd8};
        vecs[10] = '{BGEZAL | POS,         5'd4,  32'h500, 32'h0, 32'h0,    32'h0,
                     5'd31, 5'd9,  32'h500,  32'h55,   1'b1, 5'd31, 32'h500,  32'd9};
        vecs[11] = '{NONE,                 5'd9,  32'h0,   32'h0, 32'h77,   32'h0,
                     5'd9,  5'd31, 32'h55,   32'h500,  1'b0, 5'd31, 32'h500,  32'd9};
        vecs[12] = '{JALR,                 5'd0,  32'h600, 32'h0, 32'h0,    32'h0,
                     5'd0,  5'd9,  32'h0,    32'h55,   1'b0, 5'd31, 32'h500,  32'd9};
        vecs[13] = '{JALR | MEM,           5'd10, 32'h44,  32'h0, 32'h0,    32'hBB,
                     5'd10, 5'd0,  32'h44,   32'h0,    1'b1, 5'd10, 32'h44,   32'd10};
        vecs[14] = '{BLTZAL | POS,         5'd10, 32'h700, 32'h0, 32'h0,    32'h0,
                     5'd31, 5'd10, 32'h500,  32'h44,   1'b0, 5'd10, 32'h44,   32'd10};

        // Reset state, sampled before any clock edge.
        reset = 1'b1;
        drive(NONE, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
        #2;
        check("reset_rd1", bus.Read_data_1, 32'h0);
        check("reset_cv", {31'd0, bus.Commit_valid}, 32'h0);
        check("reset_ca", {27'd0, bus.Commit_address}, 32'h0);
        check("reset_cd", bus.Commit_data, 32'h0);
        check("reset_cnt", bus.Retired_count, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].flags, vecs[i].wa, vecs[i].pc4, vecs[i].cp0, vecs[i].alu,
                  vecs[i].memd, vecs[i].ra1, vecs[i].ra2);
            #1;
            check($sformatf("v%0d_rd1", i), bus.Read_data_1, vecs[i].rd1);
            check($sformatf("v%0d_rd2", i), bus.Read_data_2, vecs[i].rd2);
            @(posedge clock);
            #1;
            check($sformatf("v%0d_cv", i), {31'd0, bus.Commit_valid}, {31'd0, vecs[i].cv});
            check($sformatf("v%0d_ca", i), {27'd0, bus.Commit_address}, {27'd0, vecs[i].ca});
            check($sformatf("v%0d_cd", i), bus.Commit_data, vecs[i].cd);
            check($sformatf("v%0d_cnt", i), bus.Retired_count, vecs[i].cnt);
            @(negedge clock);
        end

        // Reset pulsed between edges clears state immediately.
        drive(NONE, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd7);
        #1;
        check("pre_reset_r5", bus.Read_data_1, 32'h1234);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_r5", bus.Read_data_1, 32'h0);
        check("midrst_r7", bus.Read_data_2, 32'h0);
        check("midrst_cv", {31'd0, bus.Commit_valid}, 32'h0);
        check("midrst_ca", {27'd0, bus.Commit_address}, 32'h0);
        check("midrst_cd", bus.Commit_data, 32'h0);
        check("midrst_cnt", bus.Retired_count, 32'h0);

        // A write presented while reset is held is discarded.
        drive(RW, 5'd5, 32'h0, 32'h0, 32'h999, 32'h0, 5'd5, 5'd0);
        @(posedge clock);
        #1;
        check("rsthold_cnt", bus.Retired_count, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        drive(NONE, 5'd5, 32'h0, 32'h0, 32'h999, 32'h0, 5'd5, 5'd0);
        #1;
        check("rsthold_r5", bus.Read_data_1, 32'h0);

        // First edge after release commits normally.
        drive(RW, 5'd6, 32'h0, 32'h0, 32'h66, 32'h0, 5'd6, 5'd5);
        @(posedge clock);
        #1;
        drive(NONE, 5'd6, 32'h0, 32'h0, 32'h66, 32'h0, 5'd6, 5'd5);
        #1;
        check("post_rst_cv", {31'd0, bus.Commit_valid}, 32'h1);
        check("post_rst_ca", {27'd0, bus.Commit_address}, 32'd6);
        check("post_rst_cnt", bus.Retired_count, 32'd1);
        check("post_rst_r6", bus.Read_data_1, 32'h66);

        // Counter wrap from 0xFFFFFFFF.
        @(negedge clock);
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        check("wrap_preset", bus.Retired_count, 32'hFFFF_FFFF);
        release dut.retired_q;
        drive(RW, 5'd11, 32'h0, 32'h0, 32'h1, 32'h0, 5'd11, 5'd0);
        @(posedge clock);
        #1;
        check("wrap_cnt", bus.Retired_count, 32'h0);
        check("wrap_cv", {31'd0, bus.Commit_valid}, 32'h1);
        check("wrap_cd", bus.Commit_data, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
